axi_lite_reg_bank: RTL and testbench
====================================

AXI_LITE_REG_BANK -- requirements
Module: axi_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, AXI-Lite byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers (1..2^(ADDR_WIDTH-2)).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the clock port is ACLK and the reset port is ARESET.
REQ-005 SHALL have port ACLK, input, 1, clock.
REQ-006 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have the AXI-Lite sink ports AWADDR/AWPROT/AWVALID in, AWREADY out; WDATA/WSTRB/WVALID in, WREADY out; BRESP[1:0]/BVALID out, BREADY in; ARADDR/ARPROT/ARVALID in, ARREADY out; RDATA/RRESP[1:0]/RVALID out, RREADY in.
REQ-008 SHALL have port reg_out, output, NUM_REGS*32, register contents, with register i at bits [32i+31:32i].
REQ-009 SHALL have port reg_wr, output, NUM_REGS, one-cycle pulse per written register.

Function
REQ-010 SHALL decode the register index as ADDR[ADDR_WIDTH-1:2] and ignore ADDR[1:0]; an index >= NUM_REGS is out of range.
REQ-011 SHALL ignore AWPROT and ARPROT.
REQ-012 SHALL capture AW and W independently: AWREADY = !aw_held && !BVALID and WREADY = !w_held && !BVALID; either may arrive first, or both in the same cycle.
REQ-013 SHALL, on the first edge where aw_held and w_held are both set, commit the write: update each byte b of the target register only where WSTRB[b]=1, pulse reg_wr[idx] for one cycle, set BVALID, and clear aw_held and w_held.
REQ-014 SHALL have a write latency where AW and W accepted at edge N give reg_out updated and BVALID high at edge N+1.
REQ-015 SHALL hold BVALID and BRESP until the BREADY handshake; the next AW or W may be accepted in the cycle after BVALID falls.
REQ-016 SHALL give BRESP=OKAY (00) for in-range writes; an out-of-range write SHALL modify nothing and SHALL NOT pulse reg_wr.
REQ-017 SHALL implement the read FSM with states R_IDLE and R_DATA, with ARREADY = (state == R_IDLE).
REQ-018 SHALL, on the AR handshake in R_IDLE, register RDATA and RRESP at that edge and move to R_DATA with RVALID=1, giving one-cycle latency.
REQ-019 SHALL hold RDATA, RRESP and RVALID in R_DATA until RREADY; on RREADY it SHALL return to R_IDLE.
REQ-020 SHALL return RDATA=0 for an out-of-range read.
REQ-021 SHALL, when a read and a write commit hit the same register on the same edge, return the pre-write value.
REQ-022 SHALL run the read and write paths concurrently and independently.

Reset
REQ-023 SHALL, on ARESET=1 and asynchronously, clear all registers, reg_wr, aw_held, w_held, BVALID, RVALID, BRESP, RRESP and RDATA to 0, and set the read FSM to R_IDLE.
REQ-024 SHALL hold AWREADY, WREADY and ARREADY at 0 while ARESET=1 and drive them per REQ-012 and REQ-017 from the first edge after release.
REQ-025 SHALL discard any transaction in flight when reset asserts, with no response issued.

Configuration
REQ-026 SHALL, with macro AXI_LITE_REG_SLVERR_EN defined, give BRESP=RRESP=SLVERR (10) for out-of-range accesses.
REQ-027 SHALL, without AXI_LITE_REG_SLVERR_EN, give OKAY for out-of-range accesses; data behaviour SHALL be identical in both builds.

Verification
REQ-028 SHALL verify: AW idx 2 and W 0xDEADBEEF with WSTRB=F in the same cycle -> reg 2 = 0xDEADBEEF, reg_wr[2] pulses once, and BVALID is high one edge after acceptance with BRESP=00.
REQ-029 SHALL verify: W 0x11223344 with WSTRB=0101 three cycles before AW idx 1, reg 1 initially 0xAABBCCDD -> reg 1 = 0xAA22CC44, and AWREADY and WREADY stay low while BVALID is high with BREADY=0.
REQ-030 SHALL verify: read idx 2 with RREADY held low for 4 cycles -> RVALID stays high, RDATA stays 0xDEADBEEF and ARREADY stays 0 until the handshake.
REQ-031 SHALL verify: write and read of idx 0 (old 0x5, new 0x9) committed on the same edge -> RDATA=0x5, then a subsequent read returns 0x9.
REQ-032 SHALL verify: write/read of idx NUM_REGS -> no register changes, RDATA=0, and resp=10 with AXI_LITE_REG_SLVERR_EN or resp=00 without it.
REQ-033 SHALL verify: ARESET asserted while BVALID=1 and aw_held=1 -> all outputs are 0 immediately and the next write completes normally after release.

Source files
------------

// File: rtl/axi_lite_reg_bank_if.sv
// AXI-Lite bus bundle for axi_lite_reg_bank: write address/data/response and read address/data channels.
interface axi_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// AXI-Lite slave register bank with byte strobes and write pulses.
// Define AXI_LITE_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_reg_bank #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_reg_bank_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic                  r_ready_en;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  r_state_t              r_state;
  r_state_t              w_state_next;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_ready;
  logic                  w_w_ready;
  logic                  w_ar_ready;
  logic                  w_rvalid;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  // r_ready_en keeps every READY low until the first edge after reset release.
  assign w_aw_ready    = r_ready_en && !r_aw_held && !r_bvalid;
  assign w_w_ready     = r_ready_en && !r_w_held && !r_bvalid;
  assign w_commit      = r_aw_held && r_w_held;
  assign w_aw_in_range = ({1'b0, r_aw_idx} < (IDX_W+1)'(NUM_REGS));
  assign w_ar_idx      = s_axi.ARADDR[ADDR_WIDTH-1:2];
  assign w_ar_in_range = ({1'b0, w_ar_idx} < (IDX_W+1)'(NUM_REGS));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_ready_en <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_in_range ? RESP_OKAY : RESP_OOR;
      end else if (r_bvalid && s_axi.BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (s_axi.AWVALID && w_aw_ready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_axi.AWADDR[ADDR_WIDTH-1:2];
      end
      if (s_axi.WVALID && w_w_ready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi.WDATA;
        r_wstrb  <= s_axi.WSTRB;
      end
    end
  end

  // Out-of-range indices never match any slot, so they modify nothing and pulse nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  w_hit;
      logic                  r_wr;
      logic [DATA_WIDTH-1:0] r_word;

      assign w_hit = w_commit && (r_aw_idx == IDX_W'(gi));

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          r_word <= '0;
          r_wr   <= 1'b0;
        end else begin
          r_wr <= w_hit;
          for (int b = 0; b < STRB_W; b++) begin
            if (w_hit && r_wstrb[b]) begin
              r_word[8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end
      end

      assign reg_out[DATA_WIDTH*gi +: DATA_WIDTH] = r_word;
      assign reg_wr[gi] = r_wr;
    end
  endgenerate

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_word = reg_out[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi.ARVALID && w_ar_ready) w_state_next = R_DATA;
      R_DATA:  if (s_axi.RREADY) w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_ar_ready = r_ready_en && (r_state == R_IDLE);
    w_rvalid   = (r_state == R_DATA);
  end

  // Sampling reg_out here yields the pre-write value when a commit lands on the same edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (s_axi.ARVALID && w_ar_ready) begin
      r_rdata <= w_rd_word;
      r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_OOR;
    end
  end

  assign s_axi.AWREADY = w_aw_ready;
  assign s_axi.WREADY  = w_w_ready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = w_ar_ready;
  assign s_axi.RVALID  = w_rvalid;
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank; honours AXI_LITE_REG_SLVERR_EN for the expected out-of-range response.
module tb_axi_lite_reg_bank;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int CW = NR * DW;
`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [CW-1:0] reg_out;
  logic [NR-1:0] reg_wr;

  axi_lite_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK    (clk),
    .ARESET  (rst),
    .s_axi   (bus.slave),
    .reg_out (reg_out),
    .reg_wr  (reg_wr)
  );

  int n_vec = 0;
  int n_mis = 0;
  logic [CW-1:0] exp_regs = '0;
  logic [1:0]    resp;
  logic [NR-1:0] wr_seen;
  logic [DW-1:0] rdata;
  bit            ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input bit pass);
    n_vec++;
    if (!pass) begin
      n_mis++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           output logic [1:0] o_resp, output logic [NR-1:0] o_wr, output bit o_ok);
    logic aw_r, w_r;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    bus.BREADY = 1'b0;
    o_ok = 1'b0; o_resp = 2'bxx; o_wr = 'x;
    for (int i = 0; i < 20; i++) begin
      aw_r = bus.AWREADY; w_r = bus.WREADY;
      tick();
      if (aw_r) bus.AWVALID = 1'b0;
      if (w_r) bus.WVALID = 1'b0;
      if (bus.BVALID) begin
        o_ok = 1'b1; o_resp = bus.BRESP; o_wr = reg_wr;
        break;
      end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] o_data,
                          output logic [1:0] o_resp, output bit o_ok);
    logic ar_r;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    o_ok = 1'b0; o_data = 'x; o_resp = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      ar_r = bus.ARREADY;
      tick();
      if (ar_r) bus.ARVALID = 1'b0;
      if (bus.RVALID) begin
        o_ok = 1'b1; o_data = bus.RDATA; o_resp = bus.RRESP;
        break;
      end
    end
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR = '0; bus.AWPROT = 3'b0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = 3'b0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_awready", bus.AWREADY === 1'b0);
    check("rst_wready", bus.WREADY === 1'b0);
    check("rst_arready", bus.ARREADY === 1'b0);
    check("rst_bvalid", bus.BVALID === 1'b0);
    check("rst_rvalid", bus.RVALID === 1'b0);
    check("rst_reg_out", reg_out === '0);
    check("rst_reg_wr", reg_wr === '0);
    rst = 1'b0;
    tick();
    check("rel_awready", bus.AWREADY === 1'b1);
    check("rel_wready", bus.WREADY === 1'b1);
    check("rel_arready", bus.ARREADY === 1'b1);

    // AW idx 2 and W same cycle
    bus.AWADDR = 10'(2 << 2); bus.AWVALID = 1'b1;
    bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("w2_bvalid_at_accept", bus.BVALID === 1'b0);
    check("w2_awready_held", bus.AWREADY === 1'b0);
    tick();
    exp_regs[2*DW +: DW] = 32'hDEADBEEF;
    check("w2_bvalid", bus.BVALID === 1'b1);
    check("w2_bresp", bus.BRESP === 2'b00);
    check("w2_reg_out", reg_out === exp_regs);
    check("w2_reg_wr", reg_wr === 8'b0000_0100);
    tick();
    check("w2_reg_wr_once", reg_wr === '0);
    check("w2_bvalid_hold", bus.BVALID === 1'b1);
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("w2_bvalid_clr", bus.BVALID === 1'b0);

    // W three cycles before AW, partial strobes
    axi_write(10'(1 << 2), 32'hAABBCCDD, 4'hF, resp, wr_seen, ok);
    exp_regs[1*DW +: DW] = 32'hAABBCCDD;
    check("w1_init_done", ok === 1'b1);
    check("w1_init_reg", reg_out === exp_regs);
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    tick(); tick();
    bus.AWADDR = 10'(1 << 2); bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    check("w1_no_early_b", bus.BVALID === 1'b0);
    tick();
    exp_regs[1*DW +: DW] = 32'hAA22CC44;
    check("w1_bvalid", bus.BVALID === 1'b1);
    check("w1_reg_out", reg_out === exp_regs);
    check("w1_reg_wr", reg_wr === 8'b0000_0010);
    bus.AWADDR = 10'(3 << 2); bus.AWVALID = 1'b1;
    bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    check("w1_awready_blk", bus.AWREADY === 1'b0);
    check("w1_wready_blk", bus.WREADY === 1'b0);
    tick();
    check("w1_awready_blk2", bus.AWREADY === 1'b0);
    check("w1_wready_blk2", bus.WREADY === 1'b0);
    check("w1_bvalid_hold", bus.BVALID === 1'b1);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("w1_awready_after", bus.AWREADY === 1'b1);
    check("w1_wready_after", bus.WREADY === 1'b1);
    check("w1_no_stray_write", reg_out === exp_regs);

    // Read idx 2 with RREADY low for 4 cycles
    bus.ARADDR = 10'(2 << 2); bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0;
    check("r2_rvalid", bus.RVALID === 1'b1);
    check("r2_rdata", bus.RDATA === 32'hDEADBEEF);
    check("r2_rresp", bus.RRESP === 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r2_rvalid_hold", bus.RVALID === 1'b1);
      check("r2_rdata_hold", bus.RDATA === 32'hDEADBEEF);
      check("r2_arready_low", bus.ARREADY === 1'b0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("r2_rvalid_clr", bus.RVALID === 1'b0);
    check("r2_arready_back", bus.ARREADY === 1'b1);

    // Same-edge write commit and read of idx 0
    axi_write(10'(0), 32'h5, 4'hF, resp, wr_seen, ok);
    exp_regs[0 +: DW] = 32'h5;
    check("w0_init_done", ok === 1'b1);
    bus.AWADDR = 10'(0); bus.AWVALID = 1'b1;
    bus.WDATA = 32'h9; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 10'(0); bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    exp_regs[0 +: DW] = 32'h9;
    check("rw0_rvalid", bus.RVALID === 1'b1);
    check("rw0_rdata_old", bus.RDATA === 32'h5);
    check("rw0_bvalid", bus.BVALID === 1'b1);
    check("rw0_reg_new", reg_out === exp_regs);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    axi_read(10'(0), rdata, resp, ok);
    check("r0_done", ok === 1'b1);
    check("r0_rdata_new", rdata === 32'h9);

    // Out-of-range index NUM_REGS
    axi_write(10'(NR << 2), 32'hFFFFFFFF, 4'hF, resp, wr_seen, ok);
    check("oor_w_done", ok === 1'b1);
    check("oor_bresp", resp === OOR);
    check("oor_reg_wr", wr_seen === '0);
    check("oor_regs", reg_out === exp_regs);
    axi_read(10'(NR << 2), rdata, resp, ok);
    check("oor_r_done", ok === 1'b1);
    check("oor_rdata", rdata === 32'h0);
    check("oor_rresp", resp === OOR);
    axi_read(10'((2 << 2) | 3), rdata, resp, ok);
    check("low_bits_ignored", rdata === 32'hDEADBEEF);

    // Reset while a write response and a read response are pending
    bus.AWADDR = 10'(3 << 2); bus.AWVALID = 1'b1;
    bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 10'(2 << 2); bus.ARVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    tick();
    check("pre_rst_bvalid", bus.BVALID === 1'b1);
    check("pre_rst_rvalid", bus.RVALID === 1'b1);
    rst = 1'b1;
    #1;
    check("arst_bvalid", bus.BVALID === 1'b0);
    check("arst_rvalid", bus.RVALID === 1'b0);
    check("arst_rdata", bus.RDATA === 32'h0);
    check("arst_bresp", bus.BRESP === 2'b00);
    check("arst_awready", bus.AWREADY === 1'b0);
    check("arst_wready", bus.WREADY === 1'b0);
    check("arst_arready", bus.ARREADY === 1'b0);
    check("arst_reg_out", reg_out === '0);
    check("arst_reg_wr", reg_wr === '0);
    exp_regs = '0;
    tick();
    rst = 1'b0;
    tick();

    // Reset with only AW held: the held address must be discarded
    bus.AWADDR = 10'(4 << 2); bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    tick(); tick();
    check("disc_no_bvalid", bus.BVALID === 1'b0);
    check("disc_regs", reg_out === exp_regs);
    bus.AWADDR = 10'(5 << 2); bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    tick();
    exp_regs[5*DW +: DW] = 32'hCAFEF00D;
    check("post_rst_bvalid", bus.BVALID === 1'b1);
    check("post_rst_bresp", bus.BRESP === 2'b00);
    check("post_rst_regs", reg_out === exp_regs);
    check("post_rst_reg_wr", reg_wr === 8'b0010_0000);
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("post_rst_bclr", bus.BVALID === 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
